// File: rtl/ps2_defs.sv
// Shared character codes and state encoding for the PS/2 line buffer.
package ps2_defs;

    localparam logic [7:0] ASCII_BS        = 8'h08;
    localparam logic [7:0] ASCII_CR        = 8'h0D;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

    typedef enum logic {
        ST_COLLECT = 1'b0,
        ST_DRAIN   = 1'b1
    } state_t;

endpackage

// File: rtl/ascii_classify.sv
// Sorts a decoded character into printable / backspace / carriage-return classes.
module ascii_classify
    import ps2_defs::*;
(
    input  logic [7:0] code,
    output logic       is_print,
    output logic       is_bs,
    output logic       is_cr
);

    assign is_print = (code >= ASCII_PRINT_MIN) && (code <= ASCII_PRINT_MAX);
    assign is_bs    = (code == ASCII_BS);
    assign is_cr    = (code == ASCII_CR);

endmodule

// File: rtl/ps2_line_buffer.sv
// Collects decoded keystrokes into an editable line and streams it out on Enter.
module ps2_line_buffer
    import ps2_defs::*;
#(
    parameter int LINE_DEPTH = 32,
    parameter int ADDR_BITS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 new_code,
    input  logic [7:0]           ascii_code,
    output logic                 out_valid,
    output logic [7:0]           out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 overflow,
    output logic                 dropped,
    output logic [ADDR_BITS:0]   line_len
);

    // The last slot is reserved for the terminator, so printable input stops one short.
    localparam logic [ADDR_BITS:0] PRINT_LIMIT = (ADDR_BITS+1)'(LINE_DEPTH - 1);

    state_t               state_q, state_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic                 overflow_q, overflow_d;
    logic                 dropped_q, dropped_d;
    logic [7:0]           mem_q [LINE_DEPTH];

    logic                 wr_en;
    logic [7:0]           wr_data;
    logic                 is_print, is_bs, is_cr;
    logic [ADDR_BITS:0]   last_idx;
    logic                 handshake;

    ascii_classify u_classify (
        .code     (ascii_code),
        .is_print (is_print),
        .is_bs    (is_bs),
        .is_cr    (is_cr)
    );

    assign last_idx  = count_q - 1'b1;
    assign out_valid = (state_q == ST_DRAIN);
    assign out_data  = mem_q[rd_ptr_q];
    assign out_last  = out_valid && ({1'b0, rd_ptr_q} == last_idx);
    assign handshake = out_valid && out_ready;
    assign line_len  = (state_q == ST_DRAIN) ? last_idx : count_q;
    assign overflow  = overflow_q;
    assign dropped   = dropped_q;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = 1'b0;
        dropped_d  = 1'b0;
        wr_en      = 1'b0;
        wr_data    = ascii_code;

        case (state_q)
            ST_COLLECT: begin
                if (new_code) begin
                    if (is_print) begin
                        if (count_q < PRINT_LIMIT) begin
                            wr_en   = 1'b1;
                            count_d = count_q + 1'b1;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else if (is_bs) begin
                        if (count_q != '0) begin
                            count_d = count_q - 1'b1;
                        end
                    end else if (is_cr) begin
                        wr_en    = 1'b1;
                        wr_data  = ASCII_CR;
                        count_d  = count_q + 1'b1;
                        rd_ptr_d = '0;
                        state_d  = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                // Input during drain is never stored, even on the final handshake edge.
                if (new_code) begin
                    dropped_d = 1'b1;
                end
                if (handshake) begin
                    if (out_last) begin
                        count_d  = '0;
                        rd_ptr_d = '0;
                        state_d  = ST_COLLECT;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ST_COLLECT;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
        end
    end

    // Storage contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[count_q[ADDR_BITS-1:0]] <= wr_data;
        end
    end

endmodule

// File: doc/ps2_line_buffer.md
Name: ps2_line_buffer

Overview:
- Downstream consumer of the PS/2-to-ASCII decoder.
- Takes its one-cycle `new_code` pulse and 8-bit `ascii_code`.
- Assembles characters into an editable line: printable characters are appended, backspace deletes, Enter commits.
- Streams the committed line out over a valid/ready byte interface, e.g. to a UART transmitter or a command parser.

Parameters:
- LINE_DEPTH, 32: total character storage, including the terminating 0x0D; a power of two.
- ADDR_BITS, 5: log2(LINE_DEPTH).

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-low; reset==0 on a rising clk edge resets the block.
- new_code  input  1  one-cycle strobe: `ascii_code` is valid this cycle.
- ascii_code  input  8  decoded character from the upstream decoder.
- out_valid  output  1  `out_data` is valid.
- out_data  output  8  line byte.
- out_last  output  1  marks the final byte of the line, which is always 0x0D.
- out_ready  input  1  the sink accepts the byte when `out_valid && out_ready`.
- overflow  output  1  one-cycle pulse: a printable character was dropped because the line was full.
- dropped  output  1  one-cycle pulse: a character arrived during DRAIN and was discarded.
- line_len  output  ADDR_BITS+1  number of characters currently held, excluding the terminator.

Behaviour:
- Reset (reset==0): state=COLLECT, count=0, rd_ptr=0, out_valid=0, out_last=0, overflow=0, dropped=0, line_len=0. Buffer contents are don't-care. Reset mid-DRAIN abandons the line immediately; `out_valid` falls on the next edge.
- Storage: LINE_DEPTH x 8 register array. Write pointer = count. Read is asynchronous from rd_ptr.
- State COLLECT, on `new_code`=1, classify `ascii_code`:
  - Printable 0x20..0x7E:
    - if count < LINE_DEPTH-1: mem[count]<=code, count+1.
    - else: no write; overflow=1 for exactly one cycle.
  - 0x08 (backspace): if count>0, count-1; else no effect. No pulse.
  - 0x0D (Enter): mem[count]<=0x0D, count+1, rd_ptr<=0, next state DRAIN. Always accepted, because one slot is reserved for it.
  - Any other value: ignored.
  - `out_valid`=0 throughout COLLECT.
- State DRAIN:
  - out_valid=1, out_data=mem[rd_ptr], out_last=(rd_ptr==count-1).
  - On out_valid && out_ready && !out_last: rd_ptr+1.
  - On out_valid && out_ready && out_last: count<=0, rd_ptr<=0, state<=COLLECT. `out_valid` is 0 on the following cycle.
  - `out_data`/`out_last` hold stable while out_ready=0.
  - new_code=1 in DRAIN: character discarded regardless of value; dropped=1 for one cycle; no state change.
- Simultaneous: new_code in the same cycle as the final handshake is still dropped, because the state at that edge is DRAIN.
- Latency: Enter strobe at edge N gives out_valid=1 after edge N, so the first byte can transfer at edge N+1. With out_ready tied high, a line of k characters drains in k+1 consecutive cycles.
- Empty line: Enter with count=0 yields a single byte 0x0D with out_last=1.
- line_len: equals count in COLLECT; holds the committed length in DRAIN.
- Pulses (overflow, dropped) are registered and deassert the cycle after.
- No combinational path from new_code/ascii_code to any output.

Decomposition:
- Shared package/header `ps2_defs`:
  - ASCII_BS=8'h08, ASCII_CR=8'h0D, ASCII_PRINT_MIN=8'h20, ASCII_PRINT_MAX=8'h7E.
  - State encodings ST_COLLECT=1'b0, ST_DRAIN=1'b1.
- Character classification is a natural small combinational sub-module, `ascii_classify`. Inputs: code. Outputs: is_print, is_bs, is_cr.
- The storage array stays inline.

Test Plan:
- Strobe 'H'(0x48), 'i'(0x69), 0x0D with out_ready=1 -> out_data sequence 0x48, 0x69, 0x0D on consecutive cycles; out_last=1 only on 0x0D; then COLLECT with line_len=0.
- Strobe 'a', 'b', 0x08, 'c', 0x0D -> stream 0x61, 0x63, 0x0D; line_len reads 2 before Enter; 0x08 with count=0 leaves line_len=0.
- Strobe 32 printable chars (0x41) then 0x0D -> first 31 stored; 32nd raises overflow for exactly 1 cycle; stream is 31x 0x41 then 0x0D with out_last.
- Enter-committed line with out_ready toggling 1,0,0,1,... -> each byte held stable while out_ready=0; no byte skipped or duplicated.
- new_code 'x' during DRAIN -> dropped pulses 1 cycle; 'x' absent from both the current and next line.
- Assert reset=0 mid-DRAIN after 1 byte sent -> next cycle out_valid=0, line_len=0; subsequent 'z', 0x0D streams 0x7A, 0x0D.
